// File: rtl/crosswalk_pkg.sv
// Shared encodings for the pedestrian crossing controller: phase codes,
// pedestrian hand-lamp control codes and one-hot vehicle lamp patterns.
package crosswalk_pkg;

  localparam logic [2:0] ENC_GREEN  = 3'd0;
  localparam logic [2:0] ENC_YELLOW = 3'd1;
  localparam logic [2:0] ENC_CLEAR1 = 3'd2;
  localparam logic [2:0] ENC_WALK   = 3'd3;
  localparam logic [2:0] ENC_FLASH  = 3'd4;
  localparam logic [2:0] ENC_CLEAR2 = 3'd5;

  typedef enum logic [2:0] {
    S_GREEN  = ENC_GREEN,
    S_YELLOW = ENC_YELLOW,
    S_CLEAR1 = ENC_CLEAR1,
    S_WALK   = ENC_WALK,
    S_FLASH  = ENC_FLASH,
    S_CLEAR2 = ENC_CLEAR2
  } state_e;

  localparam logic [1:0] HAND_OFF   = 2'b00;
  localparam logic [1:0] HAND_SOLID = 2'b01;
  localparam logic [1:0] HAND_BLINK = 2'b10;

  localparam logic [2:0] CAR_GREEN  = 3'b001;
  localparam logic [2:0] CAR_YELLOW = 3'b010;
  localparam logic [2:0] CAR_RED    = 3'b100;

  typedef struct packed {
    logic [2:0] car;
    logic [1:0] hand;
    logic       person;
  } lamps_t;

  // Lamp pattern shown while a given phase is active.
  function automatic lamps_t decode_lamps(input state_e s);
    lamps_t l;
    l = '{car: CAR_RED, hand: HAND_SOLID, person: 1'b0};
    case (s)
      S_GREEN:  l.car = CAR_GREEN;
      S_YELLOW: l.car = CAR_YELLOW;
      S_WALK: begin
        l.hand   = HAND_OFF;
        l.person = 1'b1;
      end
      S_FLASH:  l.hand = HAND_BLINK;
      default:  l.car = CAR_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven phase down-counter: loads DURATION-1 on phase entry, counts
// down on each tick and flags expiry when a tick arrives at zero.
module phase_timer #(
  parameter int unsigned     CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of the order processes are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = tick && (cnt_q == '0);

endmodule

// File: rtl/crosswalk_controller.sv
// Signalised pedestrian crossing: phase FSM, latched push-button request and
// flash-phase blink, all timed by an external tick strobe.
module crosswalk_controller
  import crosswalk_pkg::*;
#(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned GREEN_MIN_TICKS = 20,
  parameter int unsigned YELLOW_TICKS    = 3,
  parameter int unsigned CLEAR_TICKS     = 2,
  parameter int unsigned WALK_TICKS      = 7,
  parameter int unsigned FLASH_TICKS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       button,
  output logic [2:0] car_lamp,
  output logic [1:0] hand_ctrl,
  output logic       person_ctrl,
  output logic       blink,
  output logic       req_pending
);

  localparam lamps_t RESET_LAMPS = '{car: CAR_GREEN, hand: HAND_SOLID, person: 1'b0};

  state_e           state_q, state_d;
  lamps_t           lamps_q, lamps_d;
  logic             req_q, req_d;
  logic             blink_q, blink_d;
  logic             req_in;
  logic             expire;
  logic             load;
  logic [CNT_W-1:0] load_val;

  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    logic [CNT_W-1:0] len;
    len = CNT_W'(GREEN_MIN_TICKS - 1);
    case (s)
      S_YELLOW:          len = CNT_W'(YELLOW_TICKS - 1);
      S_CLEAR1, S_CLEAR2: len = CNT_W'(CLEAR_TICKS - 1);
      S_WALK:            len = CNT_W'(WALK_TICKS - 1);
      S_FLASH:           len = CNT_W'(FLASH_TICKS - 1);
      default:           len = CNT_W'(GREEN_MIN_TICKS - 1);
    endcase
    return len;
  endfunction

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (CNT_W'(GREEN_MIN_TICKS - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_comb begin
    state_d = state_q;
    // A press in the same cycle as the granting tick already counts.
    req_in  = req_q | (button && (state_q inside {S_GREEN, S_YELLOW, S_CLEAR1}));

    if (expire) begin
      case (state_q)
        S_GREEN:  if (req_in) state_d = S_YELLOW;
        S_YELLOW: state_d = S_CLEAR1;
        S_CLEAR1: state_d = S_WALK;
        S_WALK:   state_d = S_FLASH;
        S_FLASH:  state_d = S_CLEAR2;
        S_CLEAR2: state_d = S_GREEN;
        default:  state_d = S_GREEN;
      endcase
    end

    req_d = (state_d == S_WALK && state_q != S_WALK) ? 1'b0 : req_in;

    blink_d = 1'b0;
    if (state_d == S_FLASH) begin
      if (state_q != S_FLASH) blink_d = 1'b1;
      else                    blink_d = tick ? ~blink_q : blink_q;
    end

    load     = (state_d != state_q);
    load_val = phase_len(state_d);
    lamps_d  = decode_lamps(state_d);
  end

  // NOTE: asynchronous reset clears every register, pending request included,
  // the moment reset rises -- no clock edge is needed to reach a safe state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_GREEN;
      lamps_q <= RESET_LAMPS;
      req_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
      req_q   <= req_d;
      blink_q <= blink_d;
    end
  end

  assign car_lamp    = lamps_q.car;
  assign hand_ctrl   = lamps_q.hand;
  assign person_ctrl = lamps_q.person;
  assign blink       = blink_q;
  assign req_pending = req_q;

  param_nonzero_a : assert property (@(posedge clk)
    (GREEN_MIN_TICKS != 0) && (YELLOW_TICKS != 0) && (CLEAR_TICKS != 0) &&
    (WALK_TICKS != 0) && (FLASH_TICKS != 0))
    else $error("crosswalk_controller: a *_TICKS parameter is zero");

  param_fit_a : assert property (@(posedge clk)
    ($clog2(GREEN_MIN_TICKS) <= CNT_W) && ($clog2(YELLOW_TICKS) <= CNT_W) &&
    ($clog2(CLEAR_TICKS) <= CNT_W) && ($clog2(WALK_TICKS) <= CNT_W) &&
    ($clog2(FLASH_TICKS) <= CNT_W))
    else $error("crosswalk_controller: a *_TICKS parameter exceeds CNT_W");

endmodule

// File: tb/tb_crosswalk_controller.sv
// Randomised and directed bench for crosswalk_controller, checked against a
// phase-table reference model that counts elapsed ticks per phase.
module tb_crosswalk_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       button = 1'b0;
  logic [2:0] car_lamp;
  logic [1:0] hand_ctrl;
  logic       person_ctrl;
  logic       blink;
  logic       req_pending;

  crosswalk_controller #(
    .CNT_W           (8),
    .GREEN_MIN_TICKS (4),
    .YELLOW_TICKS    (2),
    .CLEAR_TICKS     (1),
    .WALK_TICKS      (3),
    .FLASH_TICKS     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .button      (button),
    .car_lamp    (car_lamp),
    .hand_ctrl   (hand_ctrl),
    .person_ctrl (person_ctrl),
    .blink       (blink),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase order: 0 GREEN, 1 YELLOW, 2 CLEAR1, 3 WALK, 4 FLASH, 5 CLEAR2.
  int         dur   [6] = '{4, 2, 1, 3, 4, 1};
  logic [2:0] car_t [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [1:0] hand_t[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01};

  int   m_ph, m_el;
  logic m_req, m_blink;

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_req = 1'b0; m_blink = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic b);
    logic req_in, leave;
    req_in = m_req | (b && (m_ph <= 2));
    leave  = 1'b0;
    if (t) begin
      if (m_el >= dur[m_ph] - 1) leave = (m_ph != 0) || req_in;
      else m_el++;
    end
    if (leave) begin
      m_ph    = (m_ph + 1) % 6;
      m_el    = 0;
      m_req   = (m_ph == 3) ? 1'b0 : req_in;
      m_blink = (m_ph == 4);
    end else begin
      m_req = req_in;
      if (m_ph == 4 && t) m_blink = ~m_blink;
    end
  endtask

  task automatic compare_all();
    check("car_lamp",    8'(car_lamp),    8'(car_t[m_ph]));
    check("hand_ctrl",   8'(hand_ctrl),   8'(hand_t[m_ph]));
    check("person_ctrl", 8'(person_ctrl), 8'(m_ph == 3));
    check("blink",       8'(blink),       8'(m_blink));
    check("req_pending", 8'(req_pending), 8'(m_req));
  endtask

  int         tick_div = 0;
  logic       last_tick;
  logic [2:0] p_car;
  logic [1:0] p_hand;
  logic       p_person;
  bit         log_blink = 0;
  logic       blink_log[$];

  task automatic step(input logic b);
    p_car = car_lamp; p_hand = hand_ctrl; p_person = person_ctrl;
    last_tick = (tick_div == 0);
    tick   = last_tick;
    button = b;
    @(posedge clk);
    model_step(last_tick, b);
    tick_div = (tick_div + 1) % 4;
    #1;
    compare_all();
    if (log_blink && hand_ctrl == 2'b10 && (p_hand != 2'b10 || last_tick))
      blink_log.push_back(blink);
  endtask

  task automatic do_reset();
    tick = 1'b0; button = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_car",    8'(car_lamp),    8'h01);
    check("rst_hand",   8'(hand_ctrl),   8'h01);
    check("rst_person", 8'(person_ctrl), 8'h00);
    check("rst_blink",  8'(blink),       8'h00);
    check("rst_req",    8'(req_pending), 8'h00);
    reset = 1'b0;
    model_reset();
    tick_div = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t, walks, lat;
    bit  seen_green, done;

    // Idle: GREEN must persist for 50 ticks with no request.
    do_reset();
    for (int c = 0; c < 200; c++) step(1'b0);

    // Single press near the first tick, full walk cycle, blink pattern logged.
    do_reset();
    step(1'b0);
    step(1'b1);
    check("req_after_press", 8'(req_pending), 8'h01);
    log_blink = 1;
    for (int c = 0; c < 100; c++) step(1'b0);
    log_blink = 0;
    check("blink_log_len", 8'(blink_log.size()), 8'd4);
    for (int i = 0; i < 4 && i < blink_log.size(); i++)
      check($sformatf("blink_pat%0d", i), 8'(blink_log[i]), 8'((i % 2) == 0));
    check("back_to_green", 8'(car_lamp), 8'h01);

    // Late press after GREEN has long expired: YELLOW on the next tick.
    do_reset();
    for (int c = 0; c < 120; c++) step(1'b0);
    while (tick_div != 2) step(1'b0);
    step(1'b1);
    lat = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(1'b0);
      if (last_tick) lat++;
      if (car_lamp == 3'b010) done = 1;
    end
    check("late_press_yellow_seen", 8'(done), 8'h01);
    check("late_press_latency", 8'(lat), 8'd1);

    // Button held: second walk 4+2+1 ticks after re-entering GREEN.
    do_reset();
    t = 0; walks = 0; seen_green = 0;
    for (int c = 0; c < 400 && walks < 2; c++) begin
      step(1'b1);
      if (p_car == 3'b100 && car_lamp == 3'b001) begin
        seen_green = 1; t = 0;
      end else if (seen_green && last_tick) t++;
      if (person_ctrl && !p_person) walks++;
    end
    check("held_two_walks", 8'(walks), 8'd2);
    check("held_regrant_ticks", 8'(t), 8'd7);

    // Presses only during WALK/FLASH are ignored.
    do_reset();
    step(1'b1);
    for (int c = 0; c < 200; c++)
      step((m_ph == 3 || m_ph == 4) ? 1'($urandom_range(0, 1)) : 1'b0);
    check("ignored_req", 8'(req_pending), 8'h00);
    check("ignored_green", 8'(car_lamp), 8'h01);

    // Asynchronous reset in the middle of FLASH.
    do_reset();
    step(1'b1);
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      step(1'b0);
      if (m_ph == 4 && m_el == 2) done = 1;
    end
    check("reached_flash", 8'(done), 8'h01);
    check("pre_rst_hand", 8'(hand_ctrl), 8'h02);
    #1 reset = 1'b1;
    #1;
    check("async_car",   8'(car_lamp),    8'h01);
    check("async_hand",  8'(hand_ctrl),   8'h01);
    check("async_blink", 8'(blink),       8'h00);
    check("async_req",   8'(req_pending), 8'h00);
    #1 reset = 1'b0;
    model_reset();
    tick_div = 0;
    for (int c = 0; c < 20; c++) step(1'b0);
    step(1'b1);
    for (int c = 0; c < 150; c++) step(1'b0);

    // Randomised traffic, occasional bursts of held button.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < 30; k++) step(1'b1);
      end else begin
        step($urandom_range(0, 23) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
